// File: rtl/pending_req_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pending_req_encoder
// Purpose  : Sequential N-to-log2(N) priority encoder. Request pulses are
//            captured into a sticky pending register; the lowest pending
//            index is presented as a binary index on a valid/ready port and
//            its pending bit is cleared only when that index is accepted.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            req        - request lines, sampled every rising edge
//            out_idx    - encoded index of the presented request
//            out_valid  - out_idx holds a request awaiting acceptance
//            out_ready  - consumer accepts out_idx with out_valid
//            pending    - current pending register
//            dup        - one-cycle pulse: request hit an already pending bit
// Revision : 1.0 - initial release
// ============================================================================
module pending_req_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         dup
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_pending;
  logic [W-1:0] r_idx;
  logic [W-1:0] w_idx_next;
  logic         r_dup;

  logic         w_xfer;
  logic [N-1:0] w_clr;
  logic [W-1:0] w_lowest;

  // A transfer happens only while presenting; out_ready alone is ignored.
  assign w_xfer = (r_state == S_PRESENT) && out_ready;

  always_comb begin
    w_clr = '0;
    if (w_xfer) begin
      w_clr[r_idx] = 1'b1;
    end
  end

  // Lowest set index of the registered pending value. Scanning downward
  // lets the last (lowest) hit win.
  always_comb begin
    w_lowest = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_lowest = i[W-1:0];
      end
    end
  end

  // Pending register and duplicate detector. A request on the bit being
  // cleared in the same cycle keeps it set and is not a duplicate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_dup     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | req;
      r_dup     <= |(req & r_pending & ~w_clr);
    end
  end

  // FSM state and presented index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state logic. The index is loaded only when leaving IDLE, so it is
  // held through PRESENT even if a lower-index request arrives, and it keeps
  // its last value after the transfer.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_state_next = S_PRESENT;
          w_idx_next   = w_lowest;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign out_idx   = r_idx;
  assign out_valid = (r_state == S_PRESENT);
  assign pending   = r_pending;
  assign dup       = r_dup;

endmodule
`default_nettype wire
